notch_coeff_ctrl: RTL and testbench

- Run-time coefficient controller for the 4-sample halfband notch filter.
- Holds a 14-entry shadow bank of 18-bit signed taps: 7 positive-chain taps, then 7 negative-chain taps.
- On commit, sequences a glitch-free update:
  - forces the filter output into bypass;
  - copies shadow to active taps one per clock;
  - waits for the DSP pipeline and delay line to flush;
  - releases bypass.
- Sits between the register bus and the filter's coeff inputs and output mux.

---
 rtl/notch_coeff_ctrl.sv | 144 ++++++++++++++
 tb/tb_notch_coeff_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/notch_coeff_ctrl.sv
// Run-time coefficient controller for the halfband notch filter.
// Holds a shadow tap bank written from the register bus. On commit it forces
// the filter output into bypass, copies shadow to active one tap per clock,
// waits for the filter pipeline to flush, then releases bypass.
module notch_coeff_ctrl #(
    parameter int NTAPS         = 14,
    parameter int CBITS         = 18,
    parameter int SETTLE_CYCLES = 24,
    parameter int BYPASS_LEAD   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   coeff_wr_i,
    input  logic [3:0]             coeff_addr_i,
    input  logic [CBITS-1:0]       coeff_dat_i,
    output logic                   coeff_err_o,
    input  logic                   update_req_i,
    output logic                   update_busy_o,
    output logic                   update_done_o,
    input  logic                   bypass_force_i,
    output logic                   bypass_o,
    output logic [NTAPS*CBITS-1:0] coeff_o
);

    localparam int IW      = $clog2(NTAPS);
    localparam int CNT_MAX = (SETTLE_CYCLES > BYPASS_LEAD) ? SETTLE_CYCLES : BYPASS_LEAD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0]    ADDR_LIMIT = 4'(NTAPS);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NTAPS - 1);
    localparam logic [CW-1:0] LEAD_LAST  = CW'(BYPASS_LEAD - 1);
    localparam logic [CW-1:0] SETL_LAST  = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_LOAD,
        S_SETTLE,
        S_DONE
    } state_t;

    // Default notch set: positive chain in taps 0-6, negative chain in 7-13.
    function automatic logic [CBITS-1:0] default_tap(input int k);
        case (k)
            0:       return CBITS'(151);
            1:       return CBITS'(340);
            2:       return CBITS'(551);
            3:       return CBITS'(761);
            4:       return CBITS'(947);
            5:       return CBITS'(1086);
            6:       return CBITS'(1160);
            7:       return CBITS'(-70);
            8:       return CBITS'(-241);
            9:       return CBITS'(-444);
            10:      return CBITS'(-657);
            11:      return CBITS'(-858);
            12:      return CBITS'(-1023);
            13:      return CBITS'(-1133);
            default: return '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [CBITS-1:0] shadow_q [NTAPS];
    logic [CBITS-1:0] active_q [NTAPS];
    logic             wr_ok;
    logic             err_d;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode plus write/request acceptance.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        wr_ok   = coeff_wr_i && (state_q == S_IDLE) && (coeff_addr_i < ADDR_LIMIT);
        err_d   = (coeff_wr_i && !wr_ok) || (update_req_i && (state_q != S_IDLE));
        case (state_q)
            S_IDLE:   if (update_req_i)          state_d = S_LEAD;
            S_LEAD:   if (cnt_q == LEAD_LAST)    state_d = S_LOAD;
            S_LOAD:   if (idx_q == IDX_LAST)     state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == SETL_LAST)    state_d = S_DONE;
            S_DONE:                              state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // Cycle and tap-index counters; both clear whenever the state changes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            if (state_q == S_LEAD || state_q == S_SETTLE) cnt_q <= cnt_q + 1'b1;
            if (state_q == S_LOAD)                        idx_q <= idx_q + 1'b1;
        end
    end

    // Shadow writes from the bus; active taps copy from shadow during LOAD only.
    // NOTE: both banks are small flop arrays that must come out of reset with
    // a usable filter, so they are reset, unlike a RAM would be.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_q[k] <= default_tap(k);
                active_q[k] <= default_tap(k);
            end
        end else begin
            if (wr_ok)               shadow_q[coeff_addr_i] <= coeff_dat_i;
            if (state_q == S_LOAD)   active_q[idx_q]        <= shadow_q[idx_q];
        end
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bypass_o      <= 1'b0;
            update_busy_o <= 1'b0;
            update_done_o <= 1'b0;
            coeff_err_o   <= 1'b0;
        end else begin
            bypass_o      <= (state_d == S_IDLE) ? bypass_force_i : 1'b1;
            update_busy_o <= (state_d != S_IDLE);
            update_done_o <= (state_d == S_DONE);
            coeff_err_o   <= err_d;
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_taps
        assign coeff_o[CBITS*g +: CBITS] = active_q[g];
    end

endmodule

// File: tb/tb_notch_coeff_ctrl.sv
// Self-checking bench for notch_coeff_ctrl. A bench-side shadow model is
// snapshotted into a queue at each commit and compared against coeff_o when
// the done pulse appears.
module tb_notch_coeff_ctrl;

    localparam int NTAPS = 14;
    localparam int CBITS = 18;
    localparam int LAT   = 41;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   coeff_wr_i;
    logic [3:0]             coeff_addr_i;
    logic [CBITS-1:0]       coeff_dat_i;
    logic                   coeff_err_o;
    logic                   update_req_i;
    logic                   update_busy_o;
    logic                   update_done_o;
    logic                   bypass_force_i;
    logic                   bypass_o;
    logic [NTAPS*CBITS-1:0] coeff_o;

    notch_coeff_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .coeff_wr_i     (coeff_wr_i),
        .coeff_addr_i   (coeff_addr_i),
        .coeff_dat_i    (coeff_dat_i),
        .coeff_err_o    (coeff_err_o),
        .update_req_i   (update_req_i),
        .update_busy_o  (update_busy_o),
        .update_done_o  (update_done_o),
        .bypass_force_i (bypass_force_i),
        .bypass_o       (bypass_o),
        .coeff_o        (coeff_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [NTAPS*CBITS-1:0] m_shadow;
    logic [NTAPS*CBITS-1:0] exp_q [$];

    function automatic logic [CBITS-1:0] tap(input int k);
        return coeff_o[CBITS*k +: CBITS];
    endfunction

    function automatic logic [NTAPS*CBITS-1:0] default_bank();
        int d [NTAPS] = '{151, 340, 551, 761, 947, 1086, 1160,
                          -70, -241, -444, -657, -858, -1023, -1133};
        logic [NTAPS*CBITS-1:0] v;
        for (int k = 0; k < NTAPS; k++) v[CBITS*k +: CBITS] = CBITS'(d[k]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [CBITS-1:0] d, input logic exp_err);
        coeff_wr_i   = 1'b1;
        coeff_addr_i = a;
        coeff_dat_i  = d;
        if (!exp_err) m_shadow[CBITS*a +: CBITS] = d;
        tick();
        coeff_wr_i = 1'b0;
        total++;
        if (coeff_err_o !== exp_err) begin
            bad++;
            $display("FAIL write_err addr=%0d: got %b required %b", a, coeff_err_o, exp_err);
        end
    endtask

    // Issues a commit; on return the bench is one cycle after the request.
    task automatic start_commit();
        update_req_i = 1'b1;
        exp_q.push_back(m_shadow);
        tick();
        update_req_i = 1'b0;
        total++;
        if (update_busy_o !== 1'b1 || bypass_o !== 1'b1) begin
            bad++;
            $display("FAIL busy_rise: got busy=%b bypass=%b required 1 1", update_busy_o, bypass_o);
        end
    endtask

    // Waits (bounded) for the done pulse, checks latency and taps against the
    // queued snapshot, then checks the cycle after done.
    task automatic wait_done(input int n_start, input string name);
        int n;
        bit seen;
        logic [NTAPS*CBITS-1:0] exp;
        n    = n_start;
        seen = 1'b0;
        while (!seen && n < 60) begin
            if (update_done_o === 1'b1) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        total++;
        if (!seen || n != LAT) begin
            bad++;
            $display("FAIL %s latency: got %0d (seen=%0b) required %0d", name, n, seen, LAT);
        end
        exp = exp_q.pop_front();
        total++;
        if (coeff_o !== exp) begin
            bad++;
            $display("FAIL %s taps: got %h required %h", name, coeff_o, exp);
        end
        tick();
        total++;
        if (update_done_o !== 1'b0 || update_busy_o !== 1'b0 || bypass_o !== bypass_force_i) begin
            bad++;
            $display("FAIL %s after_done: got done=%b busy=%b bypass=%b required 0 0 %b",
                     name, update_done_o, update_busy_o, bypass_o, bypass_force_i);
        end
    endtask

    task automatic test_reset();
        rst_i          = 1'b1;
        coeff_wr_i     = 1'b0;
        coeff_addr_i   = '0;
        coeff_dat_i    = '0;
        update_req_i   = 1'b0;
        bypass_force_i = 1'b0;
        m_shadow       = default_bank();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        total++;
        if (tap(0) !== 18'd151)     begin bad++; $display("FAIL reset_tap0: got %h required %h", tap(0), 18'd151); end
        total++;
        if (tap(6) !== 18'd1160)    begin bad++; $display("FAIL reset_tap6: got %h required %h", tap(6), 18'd1160); end
        total++;
        if (tap(7) !== 18'h3FFBA)   begin bad++; $display("FAIL reset_tap7: got %h required 3ffba", tap(7)); end
        total++;
        if (tap(13) !== 18'h3FB93)  begin bad++; $display("FAIL reset_tap13: got %h required 3fb93", tap(13)); end
        total++;
        if (coeff_o !== m_shadow)   begin bad++; $display("FAIL reset_bank: got %h required %h", coeff_o, m_shadow); end
        total++;
        if (bypass_o !== 1'b0 || update_busy_o !== 1'b0 || update_done_o !== 1'b0 || coeff_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got bypass=%b busy=%b done=%b err=%b required 0 0 0 0",
                     bypass_o, update_busy_o, update_done_o, coeff_err_o);
        end
    endtask

    task automatic test_write_commit();
        do_write(4'd3, 18'd500, 1'b0);
        start_commit();
        for (int n = 2; n <= 6; n++) tick();
        total++;
        if (tap(3) !== 18'd761) begin bad++; $display("FAIL tap3_early: got %0d required 761", tap(3)); end
        tick();
        total++;
        if (tap(3) !== 18'd500) begin bad++; $display("FAIL tap3_load: got %0d required 500", tap(3)); end
        wait_done(7, "write_commit");
    endtask

    task automatic test_reject_addr();
        do_write(4'd14, 18'd1234, 1'b1);
        tick();
        total++;
        if (coeff_err_o !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %b required 0", coeff_err_o); end
        start_commit();
        wait_done(1, "reject_addr");
    endtask

    task automatic test_reject_during_load();
        start_commit();
        for (int n = 2; n <= 5; n++) tick();
        do_write(4'd0, 18'd999, 1'b1);
        wait_done(6, "reject_load");
    endtask

    task automatic test_reject_req_settle();
        start_commit();
        for (int n = 2; n <= 25; n++) tick();
        update_req_i = 1'b1;
        tick();
        update_req_i = 1'b0;
        total++;
        if (coeff_err_o !== 1'b1) begin bad++; $display("FAIL req_busy_err: got %b required 1", coeff_err_o); end
        wait_done(26, "reject_req");
        tick();
        tick();
        total++;
        if (update_busy_o !== 1'b0 || update_done_o !== 1'b0) begin
            bad++;
            $display("FAIL req_not_queued: got busy=%b done=%b required 0 0", update_busy_o, update_done_o);
        end
    endtask

    task automatic test_simultaneous();
        coeff_wr_i   = 1'b1;
        coeff_addr_i = 4'd13;
        coeff_dat_i  = 18'h3FFFF;
        m_shadow[CBITS*13 +: CBITS] = 18'h3FFFF;
        start_commit();
        coeff_wr_i = 1'b0;
        total++;
        if (coeff_err_o !== 1'b0) begin bad++; $display("FAIL simul_err: got %b required 0", coeff_err_o); end
        wait_done(1, "simultaneous");
        total++;
        if (tap(13) !== 18'h3FFFF) begin bad++; $display("FAIL simul_tap13: got %h required 3ffff", tap(13)); end
    endtask

    task automatic test_bypass_force();
        bit held;
        bypass_force_i = 1'b1;
        tick();
        total++;
        if (bypass_o !== 1'b1) begin bad++; $display("FAIL force_idle: got %b required 1", bypass_o); end
        start_commit();
        for (int n = 2; n <= 5; n++) tick();
        bypass_force_i = 1'b0;
        held = 1'b1;
        for (int n = 6; n <= LAT; n++) begin
            tick();
            if (bypass_o !== 1'b1) held = 1'b0;
        end
        total++;
        if (!held) begin bad++; $display("FAIL bypass_held: got dropout required 1 throughout"); end
        wait_done(LAT, "bypass_force");
    endtask

    task automatic test_reset_mid_load();
        int dones;
        do_write(4'd2, 18'd77, 1'b0);
        start_commit();
        for (int n = 2; n <= 8; n++) tick();
        rst_i = 1'b1;
        #1;
        void'(exp_q.pop_front());
        m_shadow = default_bank();
        total++;
        if (coeff_o !== m_shadow) begin bad++; $display("FAIL rst_mid_taps: got %h required %h", coeff_o, m_shadow); end
        total++;
        if (bypass_o !== 1'b0 || update_busy_o !== 1'b0 || update_done_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_flags: got bypass=%b busy=%b done=%b required 0 0 0",
                     bypass_o, update_busy_o, update_done_o);
        end
        tick();
        rst_i = 1'b0;
        dones = 0;
        for (int n = 0; n < 45; n++) begin
            tick();
            if (update_done_o === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL rst_no_done: got %0d pulses required 0", dones); end
        start_commit();
        wait_done(1, "rst_shadow");
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_reject_addr();
        test_reject_during_load();
        test_reject_req_settle();
        test_simultaneous();
        test_bypass_force();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
